// File: rtl/pack_rq_pkg.sv
// Shared constants and types for the R/q zero-sum coefficient packer.
package pack_rq_pkg;

  localparam int N          = 701;
  localparam int LOGQ       = 13;
  localparam int OUT_BYTES  = 1138;
  localparam int BUF_W      = 20;
  localparam int FILL_W     = 5;
  localparam int COEF_CNT_W = $clog2(N + 1);
  localparam int BYTE_CNT_W = $clog2(OUT_BYTES + 1);

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t PACK  = 2'd1;
  localparam state_t FLUSH = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef logic [LOGQ-1:0] coef_t;

  // Number of bytes needed to hold a given number of stream bits.
  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/pack_rq0_bit_accum_fifo.sv
// 20-bit LSB-first bit accumulator: appends LOGQ-bit words at the fill point and
// retires bytes from the bottom; a push and a pop may happen in the same cycle.
module bit_accum_fifo
  import pack_rq_pkg::*;
(
  input  logic              lcl_clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  coef_t             push_data,
  input  logic              pop,
  output logic [7:0]        head,
  output logic [FILL_W-1:0] fill
);

  logic [BUF_W-1:0]  bits_q;
  logic [BUF_W-1:0]  bits_base;
  logic [BUF_W-1:0]  bits_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_base;
  logic [FILL_W-1:0] fill_d;

  // Pop first, then append at the post-pop fill point. Bits above fill stay zero,
  // which gives the zero padding of a partial final byte for free.
  always_comb begin
    bits_base = bits_q;
    fill_base = fill_q;
    if (pop) begin
      bits_base = bits_q >> 8;
      fill_base = (fill_q > FILL_W'(8)) ? (fill_q - FILL_W'(8)) : '0;
    end
    bits_d = bits_base;
    fill_d = fill_base;
    if (push) begin
      bits_d = bits_base | ({{(BUF_W-LOGQ){1'b0}}, push_data} << fill_base);
      fill_d = fill_base + FILL_W'(LOGQ);
    end
  end

  always_ff @(posedge lcl_clk) begin
    if (rst || clr) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
    end
  end

  assign head = bits_q[7:0];
  assign fill = fill_q;

endmodule

// File: rtl/pack_rq0.sv
// Serial pack_Rq0 byte packer: drops coefficient N-1, emits little-endian bytes.
// Optional build macro SUM_CHECK_EN adds a zero-sum check reported on sum_err.
module pack_rq0
  import pack_rq_pkg::*;
(
  input  logic            lcl_clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LOGQ-1:0] coef_in,
  input  logic            coef_valid,
  output logic            coef_ready,
  output logic [7:0]      byte_out,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic            busy,
`ifdef SUM_CHECK_EN
  output logic            done,
  output logic            sum_err
`else
  output logic            done
`endif
);

  state_t                  state_q;
  state_t                  state_d;
  logic [COEF_CNT_W-1:0]   coef_cnt_q;
  logic [BYTE_CNT_W-1:0]   byte_cnt_q;
  logic [FILL_W-1:0]       fill;
  logic [7:0]              head;
  logic                    coef_xfer;
  logic                    last_coef;
  logic                    push;
  logic                    pop;
  logic                    clr;
  logic                    last_pop;

  assign last_coef = (coef_cnt_q == COEF_CNT_W'(N - 1));
  assign last_pop  = (byte_cnt_q == BYTE_CNT_W'(OUT_BYTES - 1));
  assign clr       = (state_q == IDLE) && start;

  always_comb begin
    coef_ready = (state_q == PACK) && (fill < FILL_W'(8));
    byte_valid = ((state_q == PACK) && (fill >= FILL_W'(8))) ||
                 ((state_q == FLUSH) && (fill != '0));
    coef_xfer  = coef_valid && coef_ready;
    push       = coef_xfer && !last_coef;
    pop        = byte_valid && byte_ready;
  end

  assign byte_out = head;
  assign busy     = (state_q == PACK) || (state_q == FLUSH);
  assign done     = (state_q == DONE);

  bit_accum_fifo u_fifo (
    .lcl_clk   (lcl_clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .push_data (coef_in),
    .pop       (pop),
    .head      (head),
    .fill      (fill)
  );

  // An empty buffer in FLUSH only occurs when the stream ended on a byte boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = PACK;
      PACK:    if (coef_xfer && last_coef) state_d = FLUSH;
      FLUSH:   if ((pop && last_pop) || (fill == '0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge lcl_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      coef_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        coef_cnt_q <= '0;
        byte_cnt_q <= '0;
      end else begin
        if (coef_xfer) coef_cnt_q <= coef_cnt_q + 1'b1;
        if (pop)       byte_cnt_q <= byte_cnt_q + 1'b1;
      end
    end
  end

`ifdef SUM_CHECK_EN
  coef_t sum_q;
  logic  sum_err_q;

  // The accumulator includes coefficient N-1, so a valid polynomial sums to zero.
  always_ff @(posedge lcl_clk) begin
    if (rst) begin
      sum_q     <= '0;
      sum_err_q <= 1'b0;
    end else if (clr) begin
      sum_q     <= '0;
      sum_err_q <= 1'b0;
    end else begin
      if (coef_xfer) sum_q <= sum_q + coef_in;
      if ((state_q == FLUSH) && (state_d == DONE)) sum_err_q <= (sum_q != '0);
    end
  end

  assign sum_err = sum_err_q;
`endif

endmodule

// File: tb/tb_pack_rq0.sv
// Self-checking bench for pack_rq0: bit-level reference model plus directed literals.
module tb_pack_rq0;
  import pack_rq_pkg::*;

  logic            lcl_clk    = 1'b0;
  logic            rst        = 1'b1;
  logic            start      = 1'b0;
  logic [LOGQ-1:0] coef_in    = '0;
  logic            coef_valid = 1'b0;
  logic            byte_ready = 1'b0;
  logic            coef_ready;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            busy;
  logic            done;
`ifdef SUM_CHECK_EN
  logic            sum_err;
`endif

  pack_rq0 dut (
    .lcl_clk    (lcl_clk),
    .rst        (rst),
    .start      (start),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .busy       (busy),
`ifdef SUM_CHECK_EN
    .done       (done),
    .sum_err    (sum_err)
`else
    .done       (done)
`endif
  );

  always #5 lcl_clk = ~lcl_clk;

  int         tests = 0;
  int         fails = 0;
  coef_t      coefs [N];
  logic [7:0] exp_b [OUT_BYTES];
  logic [7:0] got_b [OUT_BYTES];
  int         idx = 0;
  int         done_cnt = 0;
  bit         mon_en = 1'b0;
  bit         rdy_rand = 1'b0;
  bit         rdy_fix = 1'b0;
  bit         prev_stall = 1'b0;
  bit         prev_pop = 1'b0;
  logic [7:0] prev_byte = '0;
  logic       sum_err_at_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: stream bit b comes from coefficient b/LOGQ bit b%LOGQ and lands in byte b/8 bit b%8.
  task automatic build_exp();
    for (int j = 0; j < OUT_BYTES; j++) exp_b[j] = '0;
    for (int b = 0; b < (N - 1) * LOGQ; b++) exp_b[b / 8][b % 8] = coefs[b / LOGQ][b % LOGQ];
    for (int j = 0; j < OUT_BYTES; j++) got_b[j] = 8'hxx;
  endtask

  task automatic fill_coefs(input coef_t v);
    for (int i = 0; i < N; i++) coefs[i] = v;
  endtask

  always @(posedge lcl_clk) begin
    #1;
    byte_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  always @(negedge lcl_clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_byte", 32'(byte_out), 32'(prev_byte));
      end
      if (byte_valid && byte_ready) begin
        if (idx < OUT_BYTES) begin
          got_b[idx] = byte_out;
          check($sformatf("byte%0d", idx), 32'(byte_out), 32'(exp_b[idx]));
        end else begin
          check("extra_byte", idx, OUT_BYTES - 1);
        end
        idx++;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_pop", {30'd0, prev_pop, (idx == OUT_BYTES)}, 32'd3);
`ifdef SUM_CHECK_EN
        sum_err_at_done = sum_err;
`endif
      end
      prev_stall = byte_valid && !byte_ready;
      prev_pop   = byte_valid && byte_ready;
      prev_byte  = byte_out;
    end
  end

  // Called and returning at posedge+1.
  task automatic send_coefs(input int cnt, input bit gaps);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < cnt && guard < 20000) begin
      coef_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      coef_in    = coefs[i];
      @(negedge lcl_clk);
      acc = coef_valid && coef_ready;
      @(posedge lcl_clk);
      #1;
      if (acc) i++;
      guard++;
    end
    coef_valid = 1'b0;
    check("coefs_sent", i, cnt);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge lcl_clk);
    #1;
    start = 1'b0;
  endtask

  task automatic arm(input bit rnd);
    build_exp();
    idx        = 0;
    done_cnt   = 0;
    prev_stall = 1'b0;
    prev_pop   = 1'b0;
    rdy_rand   = rnd;
    rdy_fix    = 1'b1;
    mon_en     = 1'b1;
  endtask

  task automatic run_poly(input bit rnd, input bit gaps, input bit poke_start);
    int g = 0;
    arm(rnd);
    pulse_start();
    fork
      begin
        send_coefs(N, gaps);
      end
      begin
        if (poke_start) begin
          repeat (40) @(posedge lcl_clk);
          #1;
          start = 1'b1;
          @(posedge lcl_clk);
          #1;
          start = 1'b0;
        end
      end
    join
    while (done_cnt == 0 && g < 5000) begin
      @(negedge lcl_clk);
      g++;
    end
    repeat (3) @(negedge lcl_clk);
    check("done_count", done_cnt, 1);
    check("bytes_out", idx, OUT_BYTES);
    check("busy_after", 32'(busy), 32'd0);
    mon_en = 1'b0;
    @(posedge lcl_clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge lcl_clk);
    @(negedge lcl_clk);
    check("rst_coef_ready", 32'(coef_ready), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_out", 32'(byte_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge lcl_clk);
    #1;
    rst = 1'b0;
    @(posedge lcl_clk);
    #1;

    fill_coefs('0);
    run_poly(1'b0, 1'b0, 1'b1);
    check("zero_b0", 32'(got_b[0]), 32'h00);
    check("zero_b1137", 32'(got_b[1137]), 32'h00);

    fill_coefs('0);
    coefs[0] = 13'h1FFF;
    run_poly(1'b0, 1'b0, 1'b0);
    check("c0_b0", 32'(got_b[0]), 32'hFF);
    check("c0_b1", 32'(got_b[1]), 32'h1F);
    check("c0_b2", 32'(got_b[2]), 32'h00);
    check("c0_b1137", 32'(got_b[1137]), 32'h00);

    fill_coefs('0);
    coefs[699] = 13'h1FFF;
    coefs[700] = 13'h1234;
    run_poly(1'b0, 1'b0, 1'b0);
    check("tail_b1134", 32'(got_b[1134]), 32'h00);
    check("tail_b1135", 32'(got_b[1135]), 32'h80);
    check("tail_b1136", 32'(got_b[1136]), 32'hFF);
    check("tail_b1137", 32'(got_b[1137]), 32'h0F);

    for (int i = 0; i < N; i++) coefs[i] = coef_t'($urandom_range(0, 8191));
    run_poly(1'b1, 1'b1, 1'b1);

    fill_coefs(13'h0ABC);
    arm(1'b0);
    pulse_start();
    send_coefs(300, 1'b0);
    repeat (5) @(posedge lcl_clk);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge lcl_clk);
    #1;
    rst = 1'b0;
    @(negedge lcl_clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_byte_valid", 32'(byte_valid), 32'd0);
    check("abort_coef_ready", 32'(coef_ready), 32'd0);
    @(posedge lcl_clk);
    #1;
    fill_coefs(13'h0001);
    run_poly(1'b1, 1'b0, 1'b0);
    check("restart_b0", 32'(got_b[0]), 32'h01);
    check("restart_b1", 32'(got_b[1]), 32'h20);

`ifdef SUM_CHECK_EN
    fill_coefs('0);
    coefs[0]   = 13'h0001;
    coefs[700] = 13'h1FFF;
    run_poly(1'b0, 1'b0, 1'b0);
    check("sum_zero", 32'(sum_err_at_done), 32'd0);
    coefs[700] = 13'h0000;
    run_poly(1'b0, 1'b0, 1'b0);
    check("sum_nonzero", 32'(sum_err_at_done), 32'd1);
    check("sum_err_hold", 32'(sum_err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not reach the summary, got %0d bytes required %0d", idx, OUT_BYTES);
    $fatal(1, "timeout");
  end

endmodule
